// File: rtl/mod_adder_pkg.sv
// Shared types for the pipelined modular prefix adder: stage-count enum,
// default operand width and the generate/propagate pair with its prefix operator.
package mod_adder_pkg;

    localparam int W_DEFAULT = 7;

    typedef enum logic [1:0] {
        STAGES_1 = 2'd1,
        STAGES_2 = 2'd2,
        STAGES_3 = 2'd3
    } stages_e;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Associative prefix operator: hi spans the more significant bits.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/prefix_carry_network.sv
// Kogge-Stone carry network with two independent lanes (a+b and the carry-save
// form of a+b+K). c[i] / c_k[i] is the group generate of bits i..0.
module prefix_carry_network
    import mod_adder_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] g,
    input  logic [W-1:0] p,
    input  logic [W-1:0] g_k,
    input  logic [W-1:0] p_k,
    output logic [W-1:0] c,
    output logic [W-1:0] c_k
);

    localparam int unsigned LEVELS = $clog2(W);

    function automatic logic [W-1:0] kogge_stone(input logic [W-1:0] g_in,
                                                 input logic [W-1:0] p_in);
        logic [W-1:0] gg;
        logic [W-1:0] pp;
        logic [W-1:0] gn;
        logic [W-1:0] pn;
        gp_t          hi;
        gp_t          lo;
        gp_t          r;
        int unsigned  span;
        gg = g_in;
        pp = p_in;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            span = 32'd1 << l;
            gn   = gg;
            pn   = pp;
            for (int unsigned i = span; i < W; i++) begin
                hi.g  = gg[i];
                hi.p  = pp[i];
                lo.g  = gg[i - span];
                lo.p  = pp[i - span];
                r     = gp_combine(hi, lo);
                gn[i] = r.g;
                pn[i] = r.p;
            end
            gg = gn;
            pp = pn;
        end
        return gg;
    endfunction

    always_comb begin
        c   = kogge_stone(g, p);
        c_k = kogge_stone(g_k, p_k);
    end

endmodule

// File: rtl/mod_prefix_adder_pipe.sv
// Pipelined modular adder s = (a+b) mod (2^W - K) using a dual-lane prefix network.
// Optional feature macro MODADD_WRAP_FLAG_EN adds the registered wrap output.
module mod_prefix_adder_pipe
    import mod_adder_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         k_load,
    input  logic [W-1:0] k_in,
    output logic         k_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s
`ifdef MODADD_WRAP_FLAG_EN
    ,
    output logic         wrap
`endif
);

    localparam stages_e STG     = stages_e'(STAGES[1:0]);
    localparam bit      HAS_PRE = (STG == STAGES_3);
    localparam bit      HAS_PFX = (STG != STAGES_1);

    logic [W-1:0] k_q, k_d;
    logic         pre_v_q, pre_v_d, pfx_v_q, pfx_v_d, out_v_q, out_v_d;
    logic [W-1:0] pre_g_q, pre_g_d, pre_p_q, pre_p_d;
    logic [W-1:0] pre_gk_q, pre_gk_d, pre_pk_q, pre_pk_d;
    logic         pre_cvt_q, pre_cvt_d;
    logic [W-1:0] pfx_c_q, pfx_c_d, pfx_ck_q, pfx_ck_d;
    logic [W-1:0] pfx_p_q, pfx_p_d, pfx_pk_q, pfx_pk_d;
    logic         pfx_cvt_q, pfx_cvt_d;
    logic [W-1:0] s_q, s_d;
`ifdef MODADD_WRAP_FLAG_EN
    logic         wrap_q, wrap_d;
`endif

    logic         advance, k_accept, take;
    logic [W-1:0] maj, cvs, sk;
    logic [W-1:0] g0, p0, gk0, pk0;
    logic         cvt0;
    logic [W-1:0] g1, p1, gk1, pk1;
    logic         cvt1, v1;
    logic [W-1:0] c1, ck1;
    logic [W-1:0] c2, ck2, p2, pk2;
    logic         cvt2, v2;
    logic [W-1:0] sum_ab, sum_abk;
    logic         wrap_c;

    always_comb begin
        k_ready  = !(pre_v_q | pfx_v_q | out_v_q);
        k_accept = k_load & k_ready;
        advance  = !out_v_q | out_ready;
        in_ready = advance & !k_accept;
        take     = in_valid & in_ready;
        k_d      = k_accept ? k_in : k_q;

        // Carry-save a+b+K = sk + cvs + cvt0*2^W, then prefix-add sk + cvs.
        maj  = (a & b) | (a & k_q) | (b & k_q);
        cvs  = {maj[W-2:0], 1'b0};
        cvt0 = maj[W-1];
        sk   = a ^ b ^ k_q;
        g0   = a & b;
        p0   = a ^ b;
        gk0  = sk & cvs;
        pk0  = sk ^ cvs;

        pre_g_d   = advance ? g0   : pre_g_q;
        pre_p_d   = advance ? p0   : pre_p_q;
        pre_gk_d  = advance ? gk0  : pre_gk_q;
        pre_pk_d  = advance ? pk0  : pre_pk_q;
        pre_cvt_d = advance ? cvt0 : pre_cvt_q;
        pre_v_d   = HAS_PRE ? (advance ? take : pre_v_q) : 1'b0;

        g1   = HAS_PRE ? pre_g_q   : g0;
        p1   = HAS_PRE ? pre_p_q   : p0;
        gk1  = HAS_PRE ? pre_gk_q  : gk0;
        pk1  = HAS_PRE ? pre_pk_q  : pk0;
        cvt1 = HAS_PRE ? pre_cvt_q : cvt0;
        v1   = HAS_PRE ? pre_v_q   : take;
    end

    prefix_carry_network #(
        .W (W)
    ) u_net (
        .g   (g1),
        .p   (p1),
        .g_k (gk1),
        .p_k (pk1),
        .c   (c1),
        .c_k (ck1)
    );

    always_comb begin
        pfx_c_d   = advance ? c1   : pfx_c_q;
        pfx_ck_d  = advance ? ck1  : pfx_ck_q;
        pfx_p_d   = advance ? p1   : pfx_p_q;
        pfx_pk_d  = advance ? pk1  : pfx_pk_q;
        pfx_cvt_d = advance ? cvt1 : pfx_cvt_q;
        pfx_v_d   = HAS_PFX ? (advance ? v1 : pfx_v_q) : 1'b0;

        c2   = HAS_PFX ? pfx_c_q   : c1;
        ck2  = HAS_PFX ? pfx_ck_q  : ck1;
        p2   = HAS_PFX ? pfx_p_q   : p1;
        pk2  = HAS_PFX ? pfx_pk_q  : pk1;
        cvt2 = HAS_PFX ? pfx_cvt_q : cvt1;
        v2   = HAS_PFX ? pfx_v_q   : v1;

        sum_ab  = p2  ^ {c2[W-2:0], 1'b0};
        sum_abk = pk2 ^ {ck2[W-2:0], 1'b0};
        // A carry out of a+b alone always implies a carry out of a+b+K.
        wrap_c  = cvt2 | ck2[W-1] | c2[W-1];

        out_v_d = advance ? v2 : out_v_q;
        s_d     = advance ? (wrap_c ? sum_abk : sum_ab) : s_q;
`ifdef MODADD_WRAP_FLAG_EN
        wrap_d  = advance ? wrap_c : wrap_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q       <= '0;
            pre_v_q   <= 1'b0;
            pfx_v_q   <= 1'b0;
            out_v_q   <= 1'b0;
            pre_g_q   <= '0;
            pre_p_q   <= '0;
            pre_gk_q  <= '0;
            pre_pk_q  <= '0;
            pre_cvt_q <= 1'b0;
            pfx_c_q   <= '0;
            pfx_ck_q  <= '0;
            pfx_p_q   <= '0;
            pfx_pk_q  <= '0;
            pfx_cvt_q <= 1'b0;
            s_q       <= '0;
`ifdef MODADD_WRAP_FLAG_EN
            wrap_q    <= 1'b0;
`endif
        end else begin
            k_q       <= k_d;
            pre_v_q   <= pre_v_d;
            pfx_v_q   <= pfx_v_d;
            out_v_q   <= out_v_d;
            pre_g_q   <= pre_g_d;
            pre_p_q   <= pre_p_d;
            pre_gk_q  <= pre_gk_d;
            pre_pk_q  <= pre_pk_d;
            pre_cvt_q <= pre_cvt_d;
            pfx_c_q   <= pfx_c_d;
            pfx_ck_q  <= pfx_ck_d;
            pfx_p_q   <= pfx_p_d;
            pfx_pk_q  <= pfx_pk_d;
            pfx_cvt_q <= pfx_cvt_d;
            s_q       <= s_d;
`ifdef MODADD_WRAP_FLAG_EN
            wrap_q    <= wrap_d;
`endif
        end
    end

    assign out_valid = out_v_q;
    assign s         = s_q;
`ifdef MODADD_WRAP_FLAG_EN
    assign wrap      = wrap_q;
`endif

endmodule
